melody_sequencer: RTL

- Upstream feeder for the single-tone buzzer generator.
- Steps through a built-in 16-entry note ROM and presents a 15-bit half-period divider plus a tone enable for each note, holding each note for a programmable number of tempo ticks.
- The downstream tone stage loads `divider-1` into its 15-bit counter and toggles the pin while `tone_en` is high.
- Runs at the board clock (16 MHz).

---
 rtl/melody_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer
//   Upstream feeder for the single-tone buzzer generator. Walks a built-in
//   16-entry note ROM and presents, for every note, a 15-bit half-period
//   divider plus a tone enable. Each note is held for (d+1) tempo ticks of
//   TICK_DIV clock cycles, preceded by a single LOAD cycle.
//
// Ports
//   CLK        system clock (16 MHz board clock)
//   RST        asynchronous, active-high reset
//   start      single-cycle pulse, begins playback from step 0 when idle
//   stop       single-cycle pulse, aborts playback (wins over start)
//   loop       sampled at end of melody; 1 restarts from step 0
//   divider    half-period in CLK cycles of the current note
//   tone_en    1 = downstream tone stage should sound
//   step_idx   ROM step currently playing
//   busy       high in LOAD and PLAY
//   done       one-cycle pulse on natural melody completion
//   dbg_state  current FSM state (IDLE=0, LOAD=1, PLAY=2, FINISH=3)
//
// Control protocol: start and stop are plain single-cycle request pulses
// sampled on the rising edge of CLK. There is no ready/acknowledge path;
// a start seen outside IDLE is dropped, and stop has priority over start.

module melody_sequencer #(
  parameter int unsigned TICK_DIV = 1000000,
  parameter bit          ARTIC    = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        stop,
  input  logic        loop,
  output logic [14:0] divider,
  output logic        tone_en,
  output logic [3:0]  step_idx,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_PLAY   = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  localparam int unsigned   TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [3:0]    NOTE_END  = 4'd15;

  // ROM word: [9:8] octave, [7:4] note, [3:0] duration code.
  function automatic logic [9:0] rom_word(input logic [3:0] idx);
    logic [9:0] w;
    case (idx)
      4'd0:    w = {2'd0, 4'd1,  4'd1};  // C
      4'd1:    w = {2'd0, 4'd3,  4'd1};  // D
      4'd2:    w = {2'd0, 4'd5,  4'd1};  // E
      4'd3:    w = {2'd0, 4'd6,  4'd1};  // F
      4'd4:    w = {2'd0, 4'd8,  4'd1};  // G
      4'd5:    w = {2'd0, 4'd10, 4'd1};  // A
      4'd6:    w = {2'd0, 4'd12, 4'd1};  // B
      4'd7:    w = {2'd1, 4'd1,  4'd1};  // C, one octave up
      4'd8:    w = {2'd0, 4'd0,  4'd3};  // rest, 4 ticks
      default: w = {2'd0, NOTE_END, 4'd0};
    endcase
    return w;
  endfunction

  // Octave-0 half-period dividers, round(8e6 / f).
  function automatic logic [14:0] base_div(input logic [3:0] note);
    logic [14:0] b;
    case (note)
      4'd1:    b = 15'd30578;
      4'd2:    b = 15'd28862;
      4'd3:    b = 15'd27242;
      4'd4:    b = 15'd25713;
      4'd5:    b = 15'd24270;
      4'd6:    b = 15'd22907;
      4'd7:    b = 15'd21622;
      4'd8:    b = 15'd20408;
      4'd9:    b = 15'd19263;
      4'd10:   b = 15'd18182;
      4'd11:   b = 15'd17161;
      4'd12:   b = 15'd16198;
      default: b = 15'd0;
    endcase
    return b;
  endfunction

  function automatic logic is_tone(input logic [3:0] note);
    return (note != 4'd0) && (note <= 4'd12);
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [3:0]    note_q, note_d;
  logic [3:0]    dlen_q, dlen_d;
  logic [3:0]    dur_q, dur_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [14:0]   divider_q, divider_d;
  logic [9:0]    rom_w;

  assign rom_w = rom_word(step_q);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      step_q    <= 4'd0;
      note_q    <= 4'd0;
      dlen_q    <= 4'd0;
      dur_q     <= 4'd0;
      tick_q    <= '0;
      divider_q <= 15'd0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      note_q    <= note_d;
      dlen_q    <= dlen_d;
      dur_q     <= dur_d;
      tick_q    <= tick_d;
      divider_q <= divider_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    note_d    = note_q;
    dlen_d    = dlen_q;
    dur_d     = dur_q;
    tick_d    = tick_q;
    divider_d = divider_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          step_d  = 4'd0;
        end
      end
      S_LOAD: begin
        note_d = rom_w[7:4];
        dlen_d = rom_w[3:0];
        if (rom_w[7:4] == NOTE_END) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_PLAY;
          tick_d  = '0;
          dur_d   = rom_w[3:0];
          // Rests keep the previous divider so the tone stage is not reloaded.
          if (is_tone(rom_w[7:4])) begin
            divider_d = base_div(rom_w[7:4]) >> rom_w[9:8];
          end
        end
      end
      S_PLAY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (dur_q == 4'd0) begin
            step_d = step_q + 4'd1;
            // Running off the end of the ROM behaves like an END word.
            state_d = (step_q == 4'd15) ? S_FINISH : S_LOAD;
          end else begin
            dur_d = dur_q - 4'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_FINISH: begin
        step_d  = 4'd0;
        state_d = loop ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // stop overrides everything, including a coincident start.
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      step_d  = 4'd0;
    end else if (stop) begin
      state_d = S_IDLE;
    end
  end

  // Outputs derive from flops only (plus loop/stop for done), so an
  // asynchronous reset silences the tone immediately.
  assign divider   = divider_q;
  assign step_idx  = step_q;
  assign busy      = (state_q == S_LOAD) || (state_q == S_PLAY);
  assign tone_en   = (state_q == S_PLAY) && is_tone(note_q) &&
                     !(ARTIC && (dlen_q != 4'd0) && (dur_q == 4'd0));
  assign done      = (state_q == S_FINISH) && !loop && !stop;
  assign dbg_state = state_q;

endmodule
